// File: rtl/vga_timing.sv
// 640x480@60 VGA raster timing: pixel divider, h/v counters, syncs, blanking and start pulses.
// All outputs are registered from next-state counters; en=0 freezes timing (no backpressure path).
module vga_timing #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       bright,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]      H_VIS_X  = 11'(H_VIS);
  localparam logic [10:0]      HS_BEG   = 11'(H_VIS + H_FP);
  localparam logic [10:0]      HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0]      V_VIS_X  = 11'(V_VIS);
  localparam logic [10:0]      VS_BEG   = 11'(V_VIS + V_FP);
  localparam logic [10:0]      VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic [10:0]      hx;
  logic [10:0]      vx;
  logic             advance;
  logic             h_wrap;
  logic             v_wrap;

  always_comb begin
    advance = en & pix_en;
    h_wrap  = (hcount == H_LAST);
    v_wrap  = (vcount == V_LAST);
    h_nxt   = hcount;
    v_nxt   = vcount;
    if (advance) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 10'd1;
      end
    end
    // Divider only wraps once its strobe was seen, so a freeze landing on the
    // strobe clock delays the pixel rather than dropping its advance.
    if (pix_en)
      div_nxt = '0;
    else if (div == DIV_LAST)
      div_nxt = div;
    else
      div_nxt = div + DIV_W'(1);
    hx = {1'b0, h_nxt};
    vx = {1'b0, v_nxt};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div         <= '0;
      pix_en      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      bright      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      pix_en      <= 1'b0;
      bright      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_en      <= (div_nxt == DIV_LAST);
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      bright      <= (hx < H_VIS_X) && (vx < V_VIS_X);
      hsync       <= !((hx >= HS_BEG) && (hx < HS_END));
      vsync       <= !((vx >= VS_BEG) && (vx < VS_END));
      line_start  <= advance & h_wrap;
      frame_start <= advance & h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two builds (CLK_DIV=2 and CLK_DIV=1, shortened frames),
// per-cycle scoreboard against a pixel-index model plus directed timing checks.
`timescale 1ns/1ps
module tb_vga_timing;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b1;

  logic       a_pix_en, a_bright, a_hsync, a_vsync, a_line_start, a_frame_start;
  logic [9:0] a_hcount, a_vcount;
  logic       b_pix_en, b_bright, b_hsync, b_vsync, b_line_start, b_frame_start;
  logic [9:0] b_hcount, b_vcount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing #(.CLK_DIV(2), .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .pix_en(a_pix_en),
    .hcount(a_hcount), .vcount(a_vcount), .bright(a_bright),
    .hsync(a_hsync), .vsync(a_vsync),
    .line_start(a_line_start), .frame_start(a_frame_start)
  );

  vga_timing #(.CLK_DIV(1), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .pix_en(b_pix_en),
    .hcount(b_hcount), .vcount(b_vcount), .bright(b_bright),
    .hsync(b_hsync), .vsync(b_vsync),
    .line_start(b_line_start), .frame_start(b_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a pixel index within the frame plus clocks elapsed in the current pixel.
  // Packed expectation: {pix_en, hcount, vcount, bright, hsync, vsync, line_start, frame_start}
  int          m_n[2];
  int          m_d[2];
  bit          m_pe[2];
  logic [25:0] m_exp[2];
  bit          sb_on = 1'b0;

  task automatic step(input int i, input int cdiv, input int hv, input int hfp, input int hsw,
                      input int hbp, input int vv, input int vfp, input int vsw, input int vbp);
    int ht, vt, h, v;
    bit adv, br, hs, vs;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (!reset_n) begin
      m_n[i] = 0; m_d[i] = 0; m_pe[i] = 1'b0;
      m_exp[i] = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    end else if (!en) begin
      m_pe[i] = 1'b0;
      m_exp[i][25] = 1'b0;
      m_exp[i][4]  = 1'b0;
      m_exp[i][1]  = 1'b0;
      m_exp[i][0]  = 1'b0;
    end else begin
      adv = m_pe[i];
      if (adv) begin
        m_n[i] = (m_n[i] + 1) % (ht * vt);
        m_d[i] = 0;
      end else begin
        m_d[i] = m_d[i] + 1;
      end
      m_pe[i] = (m_d[i] >= cdiv - 1);
      h  = m_n[i] % ht;
      v  = m_n[i] / ht;
      br = (h < hv) && (v < vv);
      hs = !((h >= hv + hfp) && (h < hv + hfp + hsw));
      vs = !((v >= vv + vfp) && (v < vv + vfp + vsw));
      m_exp[i] = {m_pe[i], 10'(h), 10'(v), br, hs, vs, adv && (h == 0), adv && (m_n[i] == 0)};
    end
  endtask

  always @(posedge clk) begin
    step(0, 2, 640, 16, 96, 48, 12, 2, 2, 2);
    step(1, 1, 640, 16, 96, 48, 4, 1, 1, 1);
    sb_on <= 1'b1;
  end

  always @(negedge clk) begin
    if (sb_on) begin
      check("sb_a", {6'd0, a_pix_en, a_hcount, a_vcount, a_bright, a_hsync, a_vsync,
                     a_line_start, a_frame_start}, {6'd0, m_exp[0]});
      check("sb_b", {6'd0, b_pix_en, b_hcount, b_vcount, b_bright, b_hsync, b_vsync,
                     b_line_start, b_frame_start}, {6'd0, m_exp[1]});
    end
  end

  task automatic wait_a(input int h, input int v, input int budget, input string tag);
    int k = 0;
    while (!(a_hcount == 10'(h) && a_vcount == 10'(v)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int k, hs_low, vs_low, a_ls, b_ls, bad_br;
    bit prev;

    // Reset state and first edge after release
    repeat (3) @(negedge clk);
    check("rst_h", 32'(a_hcount), 32'd0);
    check("rst_v", 32'(a_vcount), 32'd0);
    check("rst_sync", {30'd0, a_hsync, a_vsync}, 32'd3);
    check("rst_br_pe", {30'd0, a_bright, a_pix_en}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_br", 32'(a_bright), 32'd1);
    check("rel_sync", {30'd0, a_hsync, a_vsync}, 32'd3);
    check("rel_start", {30'd0, a_line_start, a_frame_start}, 32'd0);

    // Horizontal timing on the CLK_DIV=2 build
    wait_a(639, 0, 4000, "reach_639");
    check("br_639", 32'(a_bright), 32'd1);
    wait_a(640, 0, 10, "reach_640");
    check("br_640", 32'(a_bright), 32'd0);
    prev = a_hsync; k = 0;
    while (!(prev && !a_hsync) && k < 4000) begin prev = a_hsync; @(negedge clk); k++; end
    check("hs_fall_h", 32'(a_hcount), 32'd656);
    prev = a_hsync; k = 0;
    while (!(!prev && a_hsync) && k < 4000) begin prev = a_hsync; @(negedge clk); k++; end
    check("hs_rise_h", 32'(a_hcount), 32'd752);
    k = 0;
    while (!a_line_start && k < 4000) begin @(negedge clk); k++; end
    check("ls_hv", {a_hcount, a_vcount}, {10'd0, 10'd1});
    k = 0;
    do begin @(negedge clk); k++; end while (!a_line_start && k < 4000);
    check("a_line_period", 32'(k), 32'd1600);
    @(negedge clk);
    check("a_ls_width", {30'd0, a_line_start, a_hcount == 10'd0}, 32'd1);

    // CLK_DIV=1 build: one pixel per clock, 800-clock lines, one-clock line_start
    k = 0;
    while (!b_line_start && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    check("b_ls_width", {30'd0, b_line_start, b_pix_en}, 32'd1);
    check("b_h_step", 32'(b_hcount), 32'd1);
    k = 1;
    while (!b_line_start && k < 2000) begin @(negedge clk); k++; end
    check("b_line_period", 32'(k), 32'd800);

    // Mid-frame reset
    wait_a(300, 5, 20000, "reach_300_5");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("mrst_hv", {a_hcount, a_vcount}, 32'd0);
    check("mrst_out", {28'd0, a_hsync, a_vsync, a_bright, a_pix_en}, 32'hC);

    // Freeze at 100/10
    wait_a(100, 10, 20000, "reach_100_10");
    en = 1'b0;
    repeat (50) @(negedge clk);
    check("frz_hv", {a_hcount, a_vcount}, {10'd100, 10'd10});
    check("frz_br_pe", {30'd0, a_bright, a_pix_en}, 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("res_h_br", {a_hcount, 1'b0, a_bright}, {10'd100, 1'b0, 1'b1});

    // One full frame between consecutive frame_start pulses
    k = 0;
    while (!a_frame_start && k < 40000) begin @(negedge clk); k++; end
    check("fs_hv", {a_hcount, a_vcount}, 32'd0);
    k = 0; hs_low = 0; vs_low = 0; a_ls = 0; b_ls = 0; bad_br = 0;
    do begin
      @(negedge clk);
      k++;
      hs_low += int'(!a_hsync);
      vs_low += int'(!a_vsync);
      a_ls   += int'(a_line_start);
      b_ls   += int'(b_line_start);
      bad_br += int'(a_bright && a_vcount >= 10'd12);
    end while (!a_frame_start && k < 40000);
    check("frame_period", 32'(k), 32'd28800);
    check("hs_low_clk", 32'(hs_low), 32'(192 * 18));
    check("vs_low_clk", 32'(vs_low), 32'd3200);
    check("a_lines", 32'(a_ls), 32'd18);
    check("b_lines", 32'(b_ls), 32'd36);
    check("br_vblank", 32'(bad_br), 32'd0);

    // Randomised en gaps and occasional resets under the scoreboard
    for (int i = 0; i < 6000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      reset_n = ($urandom_range(0, 799) != 0);
      @(negedge clk);
    end
    en = 1'b1; reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
